// File: rtl/go_pkg.sv
// Shared definitions for the Go move-commit block.
// Contents: default board size, cell colour encodings, the pass marker used
// in last_move, the move-sequencer state enum, the board storage type and an
// opponent-colour helper.
package go_pkg;

  localparam int unsigned BOARD_N = 9;

  localparam logic [1:0] EMPTY = 2'b00;
  localparam logic [1:0] BLACK = 2'b01;
  localparam logic [1:0] WHITE = 2'b10;

  localparam logic [7:0] PASS_CODE = 8'hFF;

  typedef enum logic [3:0] {
    IDLE,
    CHECK,
    REJECT,
    PLACE,
    CAP0,   // north neighbour
    CAP1,   // south neighbour
    CAP2,   // west neighbour
    CAP3,   // east neighbour
    COMMIT
  } state_t;

  // board[row][col], 2 bits per point; storage is always 9x9.
  typedef logic [8:0][8:0][1:0] board_t;

  function automatic logic [1:0] opponent(input logic [1:0] colour);
    return (colour == BLACK) ? WHITE : BLACK;
  endfunction

endpackage

// File: rtl/go_capture_check.sv
// Single-stone capture test (purely combinational).
// Ports:
//   board      - current board
//   row, col   - point under test; may be off-board (wrapped 4-bit arithmetic)
//   mover      - colour of the player who just moved
//   capture_ok - point is on board, holds the opponent colour, and every
//                on-board orthogonal neighbour holds the mover's colour
module go_capture_check
  import go_pkg::*;
#(
  parameter int unsigned BOARD_N = go_pkg::BOARD_N
) (
  input  board_t     board,
  input  logic [3:0] row,
  input  logic [3:0] col,
  input  logic [1:0] mover,
  output logic       capture_ok
);

  localparam logic [3:0] Bound = 4'(BOARD_N);

  // Coordinates below zero wrap to 15, so one upper-bound test covers both edges.
  function automatic logic in_bounds(input logic [3:0] r, input logic [3:0] c);
    return (r < Bound) && (c < Bound);
  endfunction

  function automatic logic [1:0] cell_at(input board_t b, input logic [3:0] r,
                                         input logic [3:0] c);
    return in_bounds(r, c) ? b[r][c] : EMPTY;
  endfunction

  logic [3:0] n_row, s_row, w_col, e_col;

  always_comb begin
    n_row = row - 4'd1;
    s_row = row + 4'd1;
    w_col = col - 4'd1;
    e_col = col + 4'd1;

    capture_ok = in_bounds(row, col) && (cell_at(board, row, col) == opponent(mover));
    // Any on-board neighbour that is not the mover's colour is a liberty or a friend.
    if (in_bounds(n_row, col) && (cell_at(board, n_row, col) != mover)) capture_ok = 1'b0;
    if (in_bounds(s_row, col) && (cell_at(board, s_row, col) != mover)) capture_ok = 1'b0;
    if (in_bounds(row, w_col) && (cell_at(board, row, w_col) != mover)) capture_ok = 1'b0;
    if (in_bounds(row, e_col) && (cell_at(board, row, e_col) != mover)) capture_ok = 1'b0;
  end

endmodule

// File: rtl/move_commit.sv
// Go move sequencer: validates a requested point, places the stone, performs
// single-stone captures in N/S/W/E order, then commits turn/last-move/pass state.
// Ports:
//   clk_in, reset_n       - clock, asynchronous active-low reset
//   move_ready            - one-cycle request pulse (honoured only in IDLE, game live)
//   move_in               - {row[7:4], col[3:0]}
//   pass_in               - request is a pass
//   board                 - registered board, board[row][col]
//   turn                  - colour to move
//   my_turn               - local player may move now
//   move_done/move_reject - one-cycle result pulses
//   game_over             - sticky after two consecutive passes
//   cap_black, cap_white  - stones captured by black / by white
//   last_move             - last committed point, 8'hFF after a pass
module move_commit
  import go_pkg::*;
#(
  parameter logic [1:0]  LOCAL_COLOR = 2'b01,
  parameter int unsigned BOARD_N     = go_pkg::BOARD_N
) (
  input  logic                  clk_in,
  input  logic                  reset_n,
  input  logic                  move_ready,
  input  logic [7:0]            move_in,
  input  logic                  pass_in,
  output logic [8:0][8:0][1:0]  board,
  output logic [1:0]            turn,
  output logic                  my_turn,
  output logic                  move_done,
  output logic                  move_reject,
  output logic                  game_over,
  output logic [6:0]            cap_black,
  output logic [6:0]            cap_white,
  output logic [7:0]            last_move
);

  localparam logic [3:0] Bound = 4'(BOARD_N);

  state_t     state_q, state_d;
  board_t     board_q;
  logic [7:0] move_q;
  logic       pass_q;
  logic [1:0] turn_q;
  logic [1:0] pass_count_q;
  logic       game_over_q;
  logic [6:0] cap_black_q, cap_white_q;
  logic [7:0] last_move_q;

  logic [3:0] row_q, col_q;
  logic [3:0] cap_row, cap_col;
  logic       legal;
  logic       capture_ok;

  assign row_q = move_q[7:4];
  assign col_q = move_q[3:0];

  // Neighbour examined in the current CAPn state.
  always_comb begin
    cap_row = row_q;
    cap_col = col_q;
    unique case (state_q)
      CAP0:    cap_row = row_q - 4'd1;
      CAP1:    cap_row = row_q + 4'd1;
      CAP2:    cap_col = col_q - 4'd1;
      CAP3:    cap_col = col_q + 4'd1;
      default: ;
    endcase
  end

  always_comb begin
    legal = 1'b0;
    if ((row_q < Bound) && (col_q < Bound)) legal = (board_q[row_q][col_q] == EMPTY);
  end

  go_capture_check #(
    .BOARD_N (BOARD_N)
  ) u_capture_check (
    .board      (board_q),
    .row        (cap_row),
    .col        (cap_col),
    .mover      (turn_q),
    .capture_ok (capture_ok)
  );

  // State register
  always_ff @(posedge clk_in or negedge reset_n) begin
    if (!reset_n) state_q <= IDLE;
    else          state_q <= state_d;
  end

  // Next-state logic
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE: begin
        if (move_ready && !game_over_q) state_d = pass_in ? COMMIT : CHECK;
      end
      CHECK:   state_d = legal ? PLACE : REJECT;
      REJECT:  state_d = IDLE;
      PLACE:   state_d = CAP0;
      CAP0:    state_d = CAP1;
      CAP1:    state_d = CAP2;
      CAP2:    state_d = CAP3;
      CAP3:    state_d = COMMIT;
      COMMIT:  state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Outputs
  always_comb begin
    move_done   = (state_q == COMMIT);
    move_reject = (state_q == REJECT);
    my_turn     = (turn_q == LOCAL_COLOR) && (state_q == IDLE) && !game_over_q;
  end

  // Datapath: request latch, board and game bookkeeping
  always_ff @(posedge clk_in or negedge reset_n) begin
    if (!reset_n) begin
      board_q      <= '0;
      move_q       <= '0;
      pass_q       <= 1'b0;
      turn_q       <= BLACK;
      pass_count_q <= 2'd0;
      game_over_q  <= 1'b0;
      cap_black_q  <= 7'd0;
      cap_white_q  <= 7'd0;
      last_move_q  <= PASS_CODE;
    end else begin
      unique case (state_q)
        IDLE: begin
          if (move_ready && !game_over_q) begin
            move_q <= move_in;
            pass_q <= pass_in;
          end
        end
        PLACE: board_q[row_q][col_q] <= turn_q;
        CAP0, CAP1, CAP2, CAP3: begin
          if (capture_ok) begin
            board_q[cap_row][cap_col] <= EMPTY;
            if (turn_q == BLACK) cap_black_q <= cap_black_q + 7'd1;
            else                 cap_white_q <= cap_white_q + 7'd1;
          end
        end
        COMMIT: begin
          turn_q <= opponent(turn_q);
          if (pass_q) begin
            last_move_q  <= PASS_CODE;
            pass_count_q <= pass_count_q + 2'd1;
            if (pass_count_q == 2'd1) game_over_q <= 1'b1;
          end else begin
            last_move_q  <= move_q;
            pass_count_q <= 2'd0;
          end
        end
        default: ;
      endcase
    end
  end

  assign board     = board_q;
  assign turn      = turn_q;
  assign game_over = game_over_q;
  assign cap_black = cap_black_q;
  assign cap_white = cap_white_q;
  assign last_move = last_move_q;

endmodule

// File: doc/move_commit.md
MOVE_COMMIT -- requirements
Module: move_commit

Interface
REQ-001 SHALL have parameter LOCAL_COLOR, default 2'b01 (black), the colour this board's player controls.
REQ-002 SHALL have parameter BOARD_N, default 9, board side length.
REQ-003 clk_in  input  1  single clock; all state changes on rising edge.
REQ-004 reset_n  input  1  asynchronous, active-low reset.
REQ-005 move_ready  input  1  one-cycle move-request pulse from the cursor/input stage.
REQ-006 move_in  input  8  requested point {row[7:4], col[3:0]}.
REQ-007 pass_in  input  1  sampled with move_ready; 1 = pass, move_in ignored.
REQ-008 board  output  2 x [8:0][8:0]  registered board, 00 empty, 01 black, 10 white.
REQ-009 turn  output  2  colour to move (01/10).
REQ-010 my_turn  output  1  turn==LOCAL_COLOR & state==IDLE & ~game_over.
REQ-011 move_done  output  1  one-cycle pulse: move or pass committed.
REQ-012 move_reject  output  1  one-cycle pulse: move illegal, nothing changed.
REQ-013 game_over  output  1  sticky after two consecutive passes.
REQ-014 cap_black, cap_white  output  7 each  stones captured by black / by white.
REQ-015 last_move  output  8  last committed point; 8'hFF after a pass.

Function
REQ-016 States SHALL be IDLE, CHECK, REJECT, PLACE, CAP0..CAP3 (N,S,W,E), COMMIT.
REQ-017 In IDLE with move_ready=1 and game_over=0, the sampling edge (E0) SHALL latch move_in/pass_in and go to CHECK; pass_in=1 SHALL go directly to COMMIT.
REQ-018 move_ready outside IDLE or while game_over=1 SHALL be ignored (no reject pulse).
REQ-019 CHECK legal iff row<BOARD_N, col<BOARD_N, and board[row][col]==00; legal -> PLACE, else -> REJECT.
REQ-020 REJECT SHALL assert move_reject for one cycle, then IDLE; board, turn, counters unchanged.
REQ-021 PLACE SHALL write turn into board[row][col], then CAP0.
REQ-022 In CAPn the neighbour in direction n SHALL be cleared to 00 if in bounds, holding the opponent colour, and all of its in-bounds neighbours hold the mover's colour (single-stone capture); the mover's capture counter SHALL then increment by 1.
REQ-023 An out-of-bounds neighbour SHALL be skipped with no board or counter change; CAP0..CAP3 take one cycle each regardless.
REQ-024 COMMIT SHALL assert move_done for one cycle, toggle turn, update last_move, then go to IDLE.
REQ-025 Stone-move latency: move_done high in the cycle after edge E6; IDLE after E7. Reject: move_reject high after E1; IDLE after E2.
REQ-026 pass_count (2 bits) SHALL increment on a committed pass and clear on a committed stone move; reaching 2 SHALL set game_over in the same COMMIT.
REQ-027 Multi-stone group capture, suicide, and ko are out of scope; a suicidal placement SHALL commit normally.
REQ-028 Capture counters SHALL NOT wrap (max 81 < 127).

Reset
REQ-029 reset_n=0 SHALL asynchronously force state=IDLE, board all 00, turn=01, pass_count=0, game_over=0, cap_black=cap_white=0, last_move=8'hFF, move_done=move_reject=0.
REQ-030 Reset mid-sequence (any state) SHALL abandon the move; no partial placement survives.

Structure
REQ-031 Package go_pkg SHALL hold BOARD_N, cell encodings EMPTY/BLACK/WHITE, PASS_CODE=8'hFF, and the state enum.
REQ-032 Combinational sub-module go_capture_check SHALL take board, a point, and the mover colour, and return capture_ok; it is instantiated once and driven by the CAPn neighbour.

Verification
REQ-033 Reset, move_ready with move_in=8'h44 -> board[4][4]=01, move_done in cycle after E6, turn=10, last_move=8'h44.
REQ-034 Black at 4,4, then white request 8'h44 -> move_reject one cycle after E1; board and turn=10 unchanged.
REQ-035 move_in=8'h93 and 8'h39 -> move_reject each time; no board change.
REQ-036 White at 0,0, black at 0,1, white elsewhere, black at 1,0 -> board[0][0]=00, cap_black=1.
REQ-037 Pass, pass -> game_over=1, last_move=8'hFF; further move_ready -> no done, no reject. Pass, move, pass -> game_over=0.
REQ-038 reset_n low during CAP2 -> immediate board clear, IDLE, turn=01.
